// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - shares one single-port memory between fetch and data requesters.
// Data wins contention until the fetch side has been passed over MAX_WAIT times in a row.
module mem_port_arbiter #(
  parameter int MAX_WAIT = 4,
  parameter int TIMEOUT  = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        halt_sys,
  input  logic        if_req,
  input  logic [15:0] if_addr,
  output logic        if_valid,
  output logic [15:0] if_rdata,
  input  logic        dm_req,
  input  logic        dm_we,
  input  logic [15:0] dm_addr,
  input  logic [15:0] dm_wdata,
  output logic        dm_valid,
  output logic [15:0] dm_rdata,
  output logic        mem_req,
  output logic        mem_we,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [15:0] mem_rdata,
  output logic        stall,
  output logic        err
);

  localparam int SW = (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1);
  localparam int BW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [SW-1:0] STARVE_MAX = SW'(MAX_WAIT);
  localparam logic [BW-1:0] BUSY_LAST  = BW'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, IF_BUSY, DM_BUSY} state_t;

  state_t          r_state;
  state_t          w_next;
  logic [SW-1:0]   r_starve_cnt;
  logic [BW-1:0]   r_busy_cnt;
  logic            r_mem_req, r_mem_we, r_if_valid, r_dm_valid, r_err;
  logic [15:0]     r_mem_addr, r_mem_wdata, r_if_rdata, r_dm_rdata;
  logic            w_grant_if, w_grant_dm, w_ack, w_timeout;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= IDLE;
    else      r_state <= w_next;
  end

  always_comb begin
    w_next     = r_state;
    w_grant_if = 1'b0;
    w_grant_dm = 1'b0;
    w_ack      = 1'b0;
    w_timeout  = 1'b0;
    case (r_state)
      IDLE: begin
        if (!halt_sys) begin
          if (if_req && (!dm_req || r_starve_cnt == STARVE_MAX)) begin
            w_grant_if = 1'b1;
            w_next     = IF_BUSY;
          end else if (dm_req) begin
            w_grant_dm = 1'b1;
            w_next     = DM_BUSY;
          end
        end
      end
      IF_BUSY, DM_BUSY: begin
        // An ack arriving on the timeout cycle still counts as a normal completion.
        w_ack     = mem_ack;
        w_timeout = !mem_ack && (r_busy_cnt == BUSY_LAST);
        if (w_ack || w_timeout) w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_mem_req    <= 1'b0;
      r_mem_we     <= 1'b0;
      r_mem_addr   <= '0;
      r_mem_wdata  <= '0;
      r_if_valid   <= 1'b0;
      r_dm_valid   <= 1'b0;
      r_err        <= 1'b0;
      r_if_rdata   <= '0;
      r_dm_rdata   <= '0;
      r_starve_cnt <= '0;
      r_busy_cnt   <= '0;
    end else begin
      r_if_valid <= 1'b0;
      r_dm_valid <= 1'b0;
      r_err      <= 1'b0;
      if (w_grant_if) begin
        r_mem_req    <= 1'b1;
        r_mem_we     <= 1'b0;
        r_mem_addr   <= if_addr;
        r_mem_wdata  <= '0;
        r_starve_cnt <= '0;
      end
      if (w_grant_dm) begin
        r_mem_req   <= 1'b1;
        r_mem_we    <= dm_we;
        r_mem_addr  <= dm_addr;
        r_mem_wdata <= dm_wdata;
        if (if_req && r_starve_cnt != STARVE_MAX) r_starve_cnt <= r_starve_cnt + SW'(1);
      end
      if (r_state == IDLE)             r_busy_cnt <= '0;
      else if (r_busy_cnt != BUSY_LAST) r_busy_cnt <= r_busy_cnt + BW'(1);
      if (w_ack || w_timeout) begin
        r_mem_req <= 1'b0;
        r_err     <= w_timeout;
        if (r_state == IF_BUSY) begin
          r_if_valid <= 1'b1;
          if (w_ack) r_if_rdata <= mem_rdata;
        end else begin
          r_dm_valid <= 1'b1;
          if (w_ack && !r_mem_we) r_dm_rdata <= mem_rdata;
        end
      end
    end
  end

  assign mem_req   = r_mem_req;
  assign mem_we    = r_mem_we;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;
  assign if_valid  = r_if_valid;
  assign if_rdata  = r_if_rdata;
  assign dm_valid  = r_dm_valid;
  assign dm_rdata  = r_dm_rdata;
  assign err       = r_err;
  assign stall     = if_req & ~r_if_valid;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - scoreboard bench for mem_port_arbiter.
// Expected grants and completions are queued as stimulus is driven and checked as the DUT emits them.
module tb_mem_port_arbiter;

  logic        clk, rst, halt_sys;
  logic        if_req, if_valid, dm_req, dm_we, dm_valid;
  logic        mem_req, mem_we, mem_ack, stall, err;
  logic [15:0] if_addr, if_rdata, dm_addr, dm_wdata, dm_rdata;
  logic [15:0] mem_addr, mem_wdata, mem_rdata;

  mem_port_arbiter #(.MAX_WAIT(4), .TIMEOUT(8)) dut (
    .clk(clk), .rst(rst), .halt_sys(halt_sys),
    .if_req(if_req), .if_addr(if_addr), .if_valid(if_valid), .if_rdata(if_rdata),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_valid(dm_valid), .dm_rdata(dm_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata), .stall(stall), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [15:0] addr;
    logic        we;
    logic [15:0] wdata;
    logic [7:0]  len;
  } grant_t;

  typedef struct packed {
    logic [15:0] rdata;
    logic        err;
  } cmp_t;

  grant_t grant_q[$];
  cmp_t   if_q[$];
  cmp_t   dm_q[$];

  int n_checks = 0;
  int n_fail   = 0;
  int n_grants = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Memory model: acks in the ack_lat-th cycle of each request; ack_lat of 0 never acks.
  int          ack_lat = 1;
  int          busy_seen = 0;
  logic        ack_r = 1'b0;
  logic        stray_ack = 1'b0;
  logic [15:0] rd_xor = 16'h0000;

  always @(negedge clk) begin
    if (mem_req === 1'b1 && ack_lat != 0) begin
      busy_seen++;
      ack_r = (busy_seen == ack_lat);
    end else begin
      busy_seen = 0;
      ack_r = 1'b0;
    end
  end

  assign mem_ack   = ack_r | stray_ack;
  assign mem_rdata = mem_ack ? (mem_addr ^ rd_xor) : 16'hDEAD;

  logic   mon_prev = 1'b0;
  logic   mon_have = 1'b0;
  grant_t mon_cur;
  int     mon_len = 0;
  cmp_t   mon_c;

  always @(negedge clk) begin
    if (mem_req === 1'b1 && mon_prev !== 1'b1) begin
      n_grants++;
      mon_len = 1;
      chk("grant_expected", grant_q.size() != 0, 1'b1);
      mon_have = (grant_q.size() != 0);
      if (mon_have) begin
        mon_cur = grant_q.pop_front();
        chk("mem_addr", mem_addr, mon_cur.addr);
        chk("mem_we", mem_we, mon_cur.we);
        chk("mem_wdata", mem_wdata, mon_cur.wdata);
      end
    end else if (mem_req === 1'b1) begin
      mon_len++;
      if (mon_have) begin
        chk("mem_addr_stable", mem_addr, mon_cur.addr);
        chk("mem_we_stable", mem_we, mon_cur.we);
        chk("mem_wdata_stable", mem_wdata, mon_cur.wdata);
      end
    end else if (mon_prev === 1'b1 && mon_have) begin
      chk("mem_req_cycles", mon_len, mon_cur.len);
    end
    mon_prev = mem_req;

    chk("valid_exclusive", if_valid & dm_valid, 1'b0);
    if (if_valid === 1'b1) begin
      chk("if_valid_expected", if_q.size() != 0, 1'b1);
      if (if_q.size() != 0) begin
        mon_c = if_q.pop_front();
        chk("if_rdata", if_rdata, mon_c.rdata);
        chk("if_err", err, mon_c.err);
      end
    end
    if (dm_valid === 1'b1) begin
      chk("dm_valid_expected", dm_q.size() != 0, 1'b1);
      if (dm_q.size() != 0) begin
        mon_c = dm_q.pop_front();
        chk("dm_rdata", dm_rdata, mon_c.rdata);
        chk("dm_err", err, mon_c.err);
      end
    end
    if (err === 1'b1 && if_valid !== 1'b1 && dm_valid !== 1'b1) chk("err_without_valid", err, 1'b0);
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic push_grant(input logic [15:0] a, input logic w, input logic [15:0] d, input logic [7:0] n);
    grant_q.push_back('{addr: a, we: w, wdata: d, len: n});
  endtask

  task automatic push_if(input logic [15:0] r, input logic e);
    if_q.push_back('{rdata: r, err: e});
  endtask

  task automatic push_dm(input logic [15:0] r, input logic e);
    dm_q.push_back('{rdata: r, err: e});
  endtask

  task automatic wait_req(input int budget);
    int k = 0;
    while (mem_req !== 1'b1 && k < budget) begin
      step();
      k++;
    end
    chk("wait_mem_req", mem_req, 1'b1);
  endtask

  task automatic drain(input int budget);
    int k = 0;
    while ((grant_q.size() + if_q.size() + dm_q.size() != 0 || mem_req === 1'b1) && k < budget) begin
      step();
      k++;
    end
    step();
    step();
    chk("drain_queues", grant_q.size() + if_q.size() + dm_q.size(), 0);
  endtask

  task automatic chk_reset_outputs();
    chk("rst_mem_req", mem_req, 1'b0);
    chk("rst_mem_we", mem_we, 1'b0);
    chk("rst_mem_addr", mem_addr, 16'h0);
    chk("rst_mem_wdata", mem_wdata, 16'h0);
    chk("rst_if_valid", if_valid, 1'b0);
    chk("rst_dm_valid", dm_valid, 1'b0);
    chk("rst_err", err, 1'b0);
    chk("rst_if_rdata", if_rdata, 16'h0);
    chk("rst_dm_rdata", dm_rdata, 16'h0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded its time limit");
    $fatal(1);
  end

  initial begin
    int          base, g0, k;
    logic [15:0] exp_if_rd, exp_dm_rd;

    rst = 1'b0; halt_sys = 1'b0;
    if_req = 1'b0; if_addr = 16'h0;
    dm_req = 1'b0; dm_we = 1'b0; dm_addr = 16'h0; dm_wdata = 16'h0;
    exp_if_rd = 16'h0; exp_dm_rd = 16'h0;
    repeat (3) step();
    chk_reset_outputs();
    chk("rst_stall", stall, 1'b0);
    rst = 1'b1;
    step();

    // Single fetch, ack in the third request cycle
    ack_lat = 3; rd_xor = 16'h0010 ^ 16'hA5C3;
    push_grant(16'h0010, 1'b0, 16'h0, 8'd3);
    push_if(16'hA5C3, 1'b0);
    exp_if_rd = 16'hA5C3;
    if_req = 1'b1; if_addr = 16'h0010;
    #1;
    chk("stall_pending", stall, 1'b1);
    wait_req(20);
    if_req = 1'b0;
    drain(50);

    // Ack while idle must be ignored
    stray_ack = 1'b1;
    step();
    chk("idle_ack_ignored", {if_valid, dm_valid, err, mem_req}, 4'b0);
    stray_ack = 1'b0;
    step();

    // Contention: four data grants, then one fetch, repeated
    ack_lat = 1; rd_xor = 16'h00FF;
    for (int i = 0; i < 10; i++) begin
      if (i == 4 || i == 9) begin
        push_grant(16'h0100, 1'b0, 16'h0, 8'd1);
        push_if(16'h01FF, 1'b0);
      end else begin
        push_grant(16'h0300, 1'b0, 16'h0, 8'd1);
        push_dm(16'h03FF, 1'b0);
      end
    end
    exp_if_rd = 16'h01FF; exp_dm_rd = 16'h03FF;
    base = n_grants;
    if_req = 1'b1; if_addr = 16'h0100;
    dm_req = 1'b1; dm_addr = 16'h0300; dm_we = 1'b0; dm_wdata = 16'h0;
    k = 0;
    while (n_grants < base + 10 && k < 300) begin
      step();
      k++;
    end
    if_req = 1'b0; dm_req = 1'b0;
    chk("contention_grant_count", n_grants - base, 10);
    drain(50);

    // Data write leaves dm_rdata untouched
    ack_lat = 2;
    push_grant(16'h0200, 1'b1, 16'h1234, 8'd2);
    push_dm(exp_dm_rd, 1'b0);
    dm_req = 1'b1; dm_we = 1'b1; dm_addr = 16'h0200; dm_wdata = 16'h1234;
    wait_req(20);
    dm_req = 1'b0; dm_we = 1'b0; dm_wdata = 16'h0;
    drain(50);

    // Fetch that is never acked times out after 8 busy cycles
    ack_lat = 0;
    push_grant(16'h0040, 1'b0, 16'h0, 8'd8);
    push_if(exp_if_rd, 1'b1);
    if_req = 1'b1; if_addr = 16'h0040;
    wait_req(20);
    if_req = 1'b0;
    drain(50);

    // Halt raised during a data transaction with a fetch pending
    ack_lat = 3;
    push_grant(16'h0400, 1'b0, 16'h0, 8'd3);
    push_dm(16'h04FF, 1'b0);
    exp_dm_rd = 16'h04FF;
    dm_req = 1'b1; dm_addr = 16'h0400;
    wait_req(20);
    dm_req = 1'b0; if_req = 1'b1; if_addr = 16'h0110; halt_sys = 1'b1;
    step();
    g0 = n_grants;
    repeat (6) step();
    chk("halt_no_grant", n_grants - g0, 0);
    chk("halt_mem_req", mem_req, 1'b0);
    chk("halt_stall", stall, 1'b1);
    chk("halt_dm_completed", dm_q.size(), 0);
    ack_lat = 2;
    push_grant(16'h0110, 1'b0, 16'h0, 8'd2);
    push_if(16'h01EF, 1'b0);
    exp_if_rd = 16'h01EF;
    halt_sys = 1'b0;
    step();
    chk("halt_release_grant", mem_req, 1'b1);
    if_req = 1'b0;
    drain(50);

    // Reset in the middle of a fetch aborts it silently
    ack_lat = 0;
    push_grant(16'h0080, 1'b0, 16'h0, 8'd2);
    if_req = 1'b1; if_addr = 16'h0080;
    wait_req(20);
    if_req = 1'b0;
    step();
    step();
    rst = 1'b0;
    #1;
    chk_reset_outputs();
    exp_if_rd = 16'h0; exp_dm_rd = 16'h0;
    step();
    step();
    rst = 1'b1;

    // First fetch after reset
    ack_lat = 1; rd_xor = 16'h3C3C;
    push_grant(16'h0020, 1'b0, 16'h0, 8'd1);
    push_if(16'h0020 ^ 16'h3C3C, 1'b0);
    if_req = 1'b1; if_addr = 16'h0020;
    wait_req(20);
    if_req = 1'b0;
    drain(50);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
